// File: rtl/opb_master_single.sv
// OPB single-beat initiator: each accepted user command becomes one arbitrated OPB
// transfer (with retry, errAck and watchdog handling) and produces exactly one response.
module opb_master_single #(
  parameter int C_OPB_AWIDTH     = 32,
  parameter int C_OPB_DWIDTH     = 32,
  parameter int C_TIMEOUT_CYCLES = 16,
  parameter int C_MAX_RETRY      = 4
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  output logic                        M_request,
  output logic                        M_select,
  output logic                        M_RNW,
  output logic [0:C_OPB_AWIDTH-1]     M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
  output logic [0:C_OPB_DWIDTH-1]     M_DBus,
  output logic                        M_busLock,
  output logic                        M_seqAddr,
  input  logic                        OPB_MGrant,
  input  logic                        OPB_xferAck,
  input  logic                        OPB_errAck,
  input  logic                        OPB_retry,
  input  logic                        OPB_toutSup,
  input  logic                        OPB_timeout,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0]     cmd_addr,
  input  logic [C_OPB_DWIDTH-1:0]     cmd_wdata,
  input  logic [C_OPB_DWIDTH/8-1:0]   cmd_be,
  output logic                        rsp_valid,
  output logic [C_OPB_DWIDTH-1:0]     rsp_rdata,
  output logic [1:0]                  rsp_status
);

  localparam int BEW = C_OPB_DWIDTH / 8;
  localparam int WDW = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam int RCW = $clog2(C_MAX_RETRY + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(C_TIMEOUT_CYCLES - 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(C_MAX_RETRY - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RESP} state_t;

  state_t                  state;
  logic                    lat_rnw;
  logic [C_OPB_AWIDTH-1:0] lat_addr;
  logic [C_OPB_DWIDTH-1:0] lat_wdata;
  logic [BEW-1:0]          lat_be;
  logic [WDW-1:0]          wd_cnt;
  logic [RCW-1:0]          retry_cnt;

  logic                    done;
  logic                    retry_again;
  logic [1:0]              done_status;
  logic [C_OPB_DWIDTH-1:0] done_rdata;

  assign M_busLock = 1'b0;
  assign M_seqAddr = 1'b0;

  // Outcome of the current XFER cycle, resolved in priority order.
  always_comb begin
    done        = 1'b0;
    retry_again = 1'b0;
    done_status = 2'b00;
    done_rdata  = '0;
    if (state == XFER) begin
      if (OPB_xferAck && OPB_errAck) begin
        done        = 1'b1;
        done_status = 2'b01;
      end else if (OPB_xferAck) begin
        done = 1'b1;
        if (lat_rnw) done_rdata = OPB_DBus;
      end else if (OPB_timeout || (!OPB_toutSup && wd_cnt == WD_LAST)) begin
        done        = 1'b1;
        done_status = 2'b10;
      end else if (OPB_retry) begin
        if (retry_cnt == RC_LAST) begin
          done        = 1'b1;
          done_status = 2'b11;
        end else begin
          retry_again = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      M_request  <= 1'b0;
      M_select   <= 1'b0;
      M_RNW      <= 1'b0;
      M_ABus     <= '0;
      M_BE       <= '0;
      M_DBus     <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= 2'b00;
      lat_rnw    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      wd_cnt     <= '0;
      retry_cnt  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_rnw   <= cmd_rnw;
            lat_addr  <= cmd_addr;
            lat_wdata <= cmd_wdata;
            lat_be    <= cmd_be;
            cmd_ready <= 1'b0;
            M_request <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (OPB_MGrant) begin
            M_request <= 1'b0;
            M_select  <= 1'b1;
            M_RNW     <= lat_rnw;
            M_ABus    <= lat_addr;
            M_BE      <= lat_be;
            M_DBus    <= lat_rnw ? '0 : lat_wdata;
            wd_cnt    <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          // Shared bus lines must return to 0 the moment select drops.
          if (done || retry_again) begin
            M_select <= 1'b0;
            M_RNW    <= 1'b0;
            M_ABus   <= '0;
            M_BE     <= '0;
            M_DBus   <= '0;
            if (done) begin
              rsp_valid  <= 1'b1;
              rsp_status <= done_status;
              rsp_rdata  <= done_rdata;
              state      <= RESP;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              M_request <= 1'b1;
              state     <= REQ;
            end
          end else if (!OPB_toutSup) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          retry_cnt <= '0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opb_master_single.sv
// Bench for opb_master_single: a scripted arbiter/slave answers each attempt, and a
// per-attempt outcome model predicts status, data, select time, episodes and latency.
module tb_opb_master_single;

  localparam int TOUT = 16;
  localparam int MAXR = 4;
  localparam int K_ACK = 0, K_ERR = 1, K_RETRY = 2, K_NONE = 3, K_BUSTO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        mRequest, mSelect, mRnw, mBusLock, mSeqAddr;
  logic [0:31] mABus, mDBus;
  logic [0:3]  mBe;
  logic        opbMGrant, opbXferAck, opbErrAck, opbRetry, opbToutSup, opbTimeout;
  logic [0:31] opbDBus;
  logic        cmdValid, cmdReady, cmdRnw;
  logic [31:0] cmdAddr, cmdWdata;
  logic [3:0]  cmdBe;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic [1:0]  rspStatus;

  int nCompared = 0;
  int nMismatched = 0;

  // Per-attempt slave script: response kind, grant delay, wait cycles, toutSup cycles, data.
  int          pKind[MAXR];
  int          pG[MAXR];
  int          pW[MAXR];
  int          pS[MAXR];
  logic [31:0] pData[MAXR];

  opb_master_single #(
    .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32), .C_TIMEOUT_CYCLES(TOUT), .C_MAX_RETRY(MAXR)
  ) dut (
    .OPB_Clk(clock), .OPB_Rst(reset),
    .M_request(mRequest), .M_select(mSelect), .M_RNW(mRnw),
    .M_ABus(mABus), .M_BE(mBe), .M_DBus(mDBus),
    .M_busLock(mBusLock), .M_seqAddr(mSeqAddr),
    .OPB_MGrant(opbMGrant), .OPB_xferAck(opbXferAck), .OPB_errAck(opbErrAck),
    .OPB_retry(opbRetry), .OPB_toutSup(opbToutSup), .OPB_timeout(opbTimeout),
    .OPB_DBus(opbDBus),
    .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_rnw(cmdRnw),
    .cmd_addr(cmdAddr), .cmd_wdata(cmdWdata), .cmd_be(cmdBe),
    .rsp_valid(rspValid), .rsp_rdata(rspRdata), .rsp_status(rspStatus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic quietSlave();
    opbMGrant  = 1'b0;
    opbXferAck = 1'b0;
    opbErrAck  = 1'b0;
    opbRetry   = 1'b0;
    opbToutSup = 1'b0;
    opbTimeout = 1'b0;
    opbDBus    = '0;
  endtask

  task automatic setPlan(input int a, input int kind, input int g, input int w, input int s,
                         input logic [31:0] d);
    pKind[a] = kind;
    pG[a]    = g;
    pW[a]    = w;
    pS[a]    = s;
    pData[a] = d;
  endtask

  // Each attempt ends at the earlier of the slave's answer and the watchdog expiry
  // (idx TOUT-1+s); acks beat the watchdog on a tie, retries lose to it.
  task automatic computeExpected(input logic rnw, output logic [1:0] st, output logic [31:0] rd,
                                 output int selC, output int ep, output int lat);
    int  endIdx;
    int  toutIdx;
    bit  finished;
    st = 2'b00; rd = '0; selC = 0; ep = 0; lat = 0; finished = 0;
    for (int a = 0; a < MAXR && !finished; a++) begin
      ep++;
      lat += pG[a] + 1;
      toutIdx  = TOUT - 1 + pS[a];
      finished = 1;
      st       = 2'b10;
      endIdx   = toutIdx;
      case (pKind[a])
        K_ACK:   if (pW[a] <= toutIdx) begin endIdx = pW[a]; st = 2'b00; rd = rnw ? pData[a] : '0; end
        K_ERR:   if (pW[a] <= toutIdx) begin endIdx = pW[a]; st = 2'b01; end
        K_BUSTO: if (pW[a] < toutIdx) endIdx = pW[a];
        K_RETRY: if (pW[a] < toutIdx) begin
                   endIdx = pW[a];
                   if (a == MAXR - 1) st = 2'b11;
                   else finished = 0;
                 end
        default: ;
      endcase
      selC += endIdx + 1;
      lat  += endIdx + 1;
    end
    lat += 1;
  endtask

  task automatic applyStimulus(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be);
    logic [1:0]  eStatus;
    logic [31:0] eRdata;
    int eSel, eEp, eLat;
    int cyc = 0, reqEp = 0, selEp = 0, reqCnt = 0, selIdx = 0, selCycles = 0;
    int orbusErr = 0, busyErr = 0, a = 0;
    bit prevReq = 0, prevSel = 0, seen = 0;

    computeExpected(rnw, eStatus, eRdata, eSel, eEp, eLat);
    @(negedge clock);
    checkOutput("ready_before", cmdReady, 1);
    quietSlave();
    cmdValid = 1'b1; cmdRnw = rnw; cmdAddr = addr; cmdWdata = wdata; cmdBe = be;

    while (!seen && cyc < 600) begin
      @(negedge clock);
      cyc++;
      if (mSelect) begin
        selCycles++;
        if (mRnw !== rnw || mABus !== addr || mBe !== be || mDBus !== (rnw ? 32'h0 : wdata))
          orbusErr++;
      end else if (mRnw !== 1'b0 || mABus !== 32'h0 || mBe !== 4'h0 || mDBus !== 32'h0) begin
        orbusErr++;
      end
      if (cmdReady !== 1'b0) busyErr++;
      if (rspValid) begin
        seen = 1;
        checkOutput("latency", cyc, eLat);
        checkOutput("status", rspStatus, eStatus);
        checkOutput("rdata", rspRdata, eRdata);
      end

      // Command lines wander while busy; the latched copy must be what appears on the bus.
      cmdValid = seen ? 1'b0 : 1'($urandom_range(0, 1));
      cmdRnw   = 1'($urandom_range(0, 1));
      cmdAddr  = $urandom;
      cmdWdata = $urandom;
      cmdBe    = 4'($urandom);
      quietSlave();
      opbDBus = $urandom;
      if (mRequest) begin
        if (!prevReq) begin reqEp++; reqCnt = 0; end
        else reqCnt++;
        a = (reqEp <= MAXR) ? reqEp - 1 : MAXR - 1;
        opbMGrant = (reqCnt == pG[a]);
      end else begin
        opbMGrant = ($urandom_range(0, 3) == 0);
      end
      if (mSelect) begin
        if (!prevSel) begin selEp++; selIdx = 0; end
        else selIdx++;
        a = (selEp <= MAXR) ? selEp - 1 : MAXR - 1;
        opbToutSup = (selIdx < pS[a]);
        if (selIdx == pW[a]) begin
          case (pKind[a])
            K_ACK:   begin opbXferAck = 1'b1; opbDBus = pData[a]; end
            K_ERR:   begin opbXferAck = 1'b1; opbErrAck = 1'b1; end
            K_RETRY: opbRetry = 1'b1;
            K_BUSTO: opbTimeout = 1'b1;
            default: ;
          endcase
        end
      end else begin
        opbXferAck = ($urandom_range(0, 5) == 0);
        opbErrAck  = ($urandom_range(0, 5) == 0);
        opbRetry   = ($urandom_range(0, 5) == 0);
        opbToutSup = 1'($urandom_range(0, 1));
      end
      prevReq = mRequest;
      prevSel = mSelect;
    end

    if (!seen) begin
      checkOutput("rsp_bound", 0, 1);
      quietSlave();
      cmdValid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
    end else begin
      @(negedge clock);
      quietSlave();
      checkOutput("hold_after", {rspValid, cmdReady, rspStatus, rspRdata},
                  {1'b0, 1'b1, eStatus, eRdata});
      checkOutput("sel_cycles", selCycles, eSel);
      checkOutput("episodes", selEp, eEp);
      checkOutput("orbus", orbusErr, 0);
      checkOutput("busy_ready", busyErr, 0);
    end
  endtask

  task automatic resetMidXfer();
    int rspSeen = 0;
    int guard = 0;
    @(negedge clock);
    quietSlave();
    cmdValid = 1'b1; cmdRnw = 1'b0; cmdAddr = 32'hA5A5_0010; cmdWdata = 32'h0BAD_F00D; cmdBe = 4'hF;
    @(negedge clock);
    cmdValid  = 1'b0;
    opbMGrant = 1'b1;
    while (!mSelect && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("rst_sel_up", mSelect, 1);
    opbMGrant = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rst_mid", {mSelect, mRequest, cmdReady, rspValid, mABus, mDBus},
                {4'b0010, 64'h0});
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (rspValid) rspSeen++;
    end
    checkOutput("rst_no_rsp", rspSeen, 0);
  endtask

  initial begin
    reset = 1'b1;
    quietSlave();
    cmdValid = 1'b0; cmdRnw = 1'b0; cmdAddr = '0; cmdWdata = '0; cmdBe = '0;
    repeat (3) @(negedge clock);
    checkOutput("rst_ctrl", {cmdReady, mRequest, mSelect, mRnw, mBusLock, mSeqAddr, rspValid, rspStatus},
                {1'b1, 8'h00});
    checkOutput("rst_bus", {mABus, mDBus}, 64'h0);
    checkOutput("rst_be_rd", {mBe, rspRdata}, 36'h0);
    reset = 1'b0;

    for (int a = 0; a < MAXR; a++) setPlan(a, K_ACK, 0, 0, 0, 32'h0);
    applyStimulus(1'b0, 32'h0001_0004, 32'hDEAD_BEEF, 4'hF);

    setPlan(0, K_ACK, 0, 3, 0, 32'h1234_5678);
    applyStimulus(1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF);

    setPlan(0, K_ERR, 0, 0, 0, 32'hCAFE_CAFE);
    applyStimulus(1'b1, 32'h0000_0200, 32'h0, 4'h3);

    setPlan(0, K_NONE, 0, 0, 0, 32'h0);
    applyStimulus(1'b0, 32'h0000_0300, 32'h5555_AAAA, 4'hC);

    setPlan(0, K_NONE, 1, 0, 20, 32'h0);
    applyStimulus(1'b0, 32'h0000_0304, 32'h1111_2222, 4'h1);

    for (int a = 0; a < MAXR; a++) setPlan(a, K_RETRY, a % 2, 0, 0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0400, 32'h0, 4'hF);

    setPlan(0, K_RETRY, 0, 1, 0, 32'h0);
    setPlan(1, K_RETRY, 2, 0, 0, 32'h0);
    setPlan(2, K_ACK, 0, 2, 0, 32'h0F0F_F0F0);
    applyStimulus(1'b1, 32'h0000_0500, 32'h0, 4'hF);

    resetMidXfer();
    for (int a = 0; a < MAXR; a++) setPlan(a, K_ACK, 0, 0, 0, 32'h7777_8888);
    applyStimulus(1'b1, 32'h0000_0600, 32'h0, 4'hF);

    for (int t = 0; t < 60; t++) begin
      for (int a = 0; a < MAXR; a++) begin
        int r;
        int k;
        r = $urandom_range(0, 99);
        k = (r < 40) ? K_ACK : (r < 50) ? K_ERR : (r < 80) ? K_RETRY : (r < 90) ? K_NONE : K_BUSTO;
        setPlan(a, k, $urandom_range(0, 3), $urandom_range(0, 19),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, $urandom);
      end
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
